gate_unit_arbiter: RTL
======================

GATE_UNIT_ARBITER -- requirements
Module: gate_unit_arbiter

Interface
- REQ-001: Parameter WIDTH, default 8, SHALL set the operand and result width in bits.
- REQ-002: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-003: rst  input  1  SHALL be the reset, synchronous and active-high.
- REQ-004: reqN_valid  input  1  (N=0,1) SHALL indicate that requester N presents an operation.
- REQ-005: reqN_ready  output  1  SHALL indicate that the arbiter accepts requester N this cycle.
- REQ-006: reqN_op  input  3  SHALL select the gate: 0 NOT_B, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal.
- REQ-007: reqN_a, reqN_b  input  WIDTH  SHALL be the operands, applied bitwise.
- REQ-008: rsp_valid  output  1  SHALL flag a valid result.
- REQ-009: rsp_ready  input  1  SHALL flag that the consumer accepts the result.
- REQ-010: rsp_id  output  1  SHALL identify the requester that owns the result.
- REQ-011: rsp_data  output  WIDTH  SHALL carry the result.
- REQ-012: rsp_err  output  1  SHALL flag an illegal opcode.
- REQ-013: busy  output  1  SHALL be high in every state except IDLE.

Function
- REQ-014: The FSM SHALL have the states IDLE, EXEC and RESP, with reset to IDLE.
- REQ-015: In IDLE, if any reqN_valid is high, the block SHALL assert reqN_ready combinationally for exactly one winner. It SHALL capture that winner's op, a, b and id on the clock edge and move to EXEC.
- REQ-016: reqN_ready SHALL be 0 outside IDLE, and SHALL never be high for both requesters at once.
- REQ-017: Arbitration SHALL be round-robin. If only one request is valid, that requester wins. If both are valid, the requester selected by the priority pointer wins.
- REQ-018: The priority pointer SHALL reset to 0. It SHALL be set to the other requester only when a response handshake completes (rsp_valid & rsp_ready).
- REQ-019: EXEC SHALL compute the selected gate over all WIDTH bits, register the result into rsp_data, rsp_id and rsp_err, and move to RESP. The result SHALL be one cycle after the accept.
- REQ-020: In RESP, rsp_valid SHALL be 1. rsp_data, rsp_id and rsp_err SHALL hold stable until rsp_ready is high. The FSM SHALL then return to IDLE on that edge.
- REQ-021: Latency SHALL be: accept edge at cycle N, rsp_valid high from cycle N+2. Minimum issue interval SHALL be 3 cycles.
- REQ-022: For opcode 7, rsp_data SHALL be all zeros and rsp_err SHALL be 1. For opcodes 0-6, rsp_err SHALL be 0.
- REQ-023: Requester input changes after acceptance SHALL NOT affect an in-flight result.
- REQ-024: If rsp_ready is already high when RESP is entered, the handshake SHALL complete in that first RESP cycle.

Reset
- REQ-025: On rst high at a clock edge, the block SHALL set state to IDLE, the pointer to 0, rsp_valid to 0, rsp_data to 0, rsp_id to 0 and rsp_err to 0.
- REQ-026: A reset mid-operation (EXEC or RESP) SHALL discard the in-flight result. No response SHALL be issued for it.
- REQ-027: While rst is high, reqN_ready SHALL be 0.

Configuration
- REQ-028: The macro GATE_ARB_STATS_EN, when defined, SHALL add two outputs, stat_cnt0 and stat_cnt1 (8 bits each).
  - Each counter SHALL count completed responses for its requester and saturate at 255.
  - Both counters SHALL clear on rst.
- REQ-029: Without GATE_ARB_STATS_EN, the stat ports and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
- REQ-030: Single request: req0 op=1, a=0xF0, b=0x3C, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_data=0x30, rsp_id=0, rsp_err=0.
- REQ-031: Op sweep on req1 with a=0xA5, b=0x0F, op 0..6 -> rsp_data 0xF0, 0x05, 0xAF, 0xFA, 0x50, 0xAA, 0x55, in order.
- REQ-032: Both requesters continuously valid after reset -> grants alternate 0,1,0,1 over 4 transactions.
- REQ-033: Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_data stable, both ready lines 0, busy=1; rsp_ready=1 -> return to IDLE next edge.
- REQ-034: Illegal op=7 -> rsp_data=0x00, rsp_err=1.
- REQ-035: rst pulsed during EXEC -> no rsp_valid, pointer=0. With GATE_ARB_STATS_EN, 300 req0 transactions -> stat_cnt0=255.

Source files
------------

// File: rtl/gate_unit_arbiter.sv
// Two-requester round-robin arbiter in front of a registered bitwise gate unit (IDLE -> EXEC -> RESP).
// Define GATE_ARB_STATS_EN to add saturating per-requester completion counters (stat_cnt0/stat_cnt1).
module gate_unit_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
`ifdef GATE_ARB_STATS_EN
    output logic [7:0]       stat_cnt0,
    output logic [7:0]       stat_cnt1,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] rspData_q, rspData_d;
    logic             rspId_q, rspId_d;
    logic             rspErr_q, rspErr_d;
    logic             grant0, grant1;
    logic [WIDTH-1:0] gateResult;
    logic             gateErr;

    always_comb begin
        gateResult = '0;
        gateErr    = 1'b0;
        case (op_q)
            3'd0:    gateResult = ~b_q;
            3'd1:    gateResult = a_q & b_q;
            3'd2:    gateResult = a_q | b_q;
            3'd3:    gateResult = ~(a_q & b_q);
            3'd4:    gateResult = ~(a_q | b_q);
            3'd5:    gateResult = a_q ^ b_q;
            3'd6:    gateResult = ~(a_q ^ b_q);
            default: gateErr    = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        rspData_d = rspData_q;
        rspId_d   = rspId_q;
        rspErr_d  = rspErr_q;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state_q)
            IDLE: begin
                // The pointer only breaks ties; a lone requester always wins.
                if (!rst) begin
                    if (req0_valid && (!req1_valid || !ptr_q)) begin
                        grant0 = 1'b1;
                    end else if (req1_valid) begin
                        grant1 = 1'b1;
                    end
                end
                if (grant0) begin
                    op_d    = req0_op;
                    a_d     = req0_a;
                    b_d     = req0_b;
                    id_d    = 1'b0;
                    state_d = EXEC;
                end else if (grant1) begin
                    op_d    = req1_op;
                    a_d     = req1_a;
                    b_d     = req1_b;
                    id_d    = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rspData_d = gateResult;
                rspErr_d  = gateErr;
                rspId_d   = id_q;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    ptr_d   = ~rspId_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            rspData_q <= '0;
            rspId_q   <= 1'b0;
            rspErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            id_q      <= id_d;
            rspData_q <= rspData_d;
            rspId_q   <= rspId_d;
            rspErr_q  <= rspErr_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rspId_q;
    assign rsp_data   = rspData_q;
    assign rsp_err    = rspErr_q;
    assign busy       = (state_q != IDLE);

`ifdef GATE_ARB_STATS_EN
    logic [7:0] cnt0_q, cnt1_q;

    // Counters advance on each completed response handshake and stick at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= 8'd0;
            cnt1_q <= 8'd0;
        end else if ((state_q == RESP) && rsp_ready) begin
            if (!rspId_q) begin
                if (cnt0_q != 8'hFF) cnt0_q <= cnt0_q + 8'd1;
            end else begin
                if (cnt1_q != 8'hFF) cnt1_q <= cnt1_q + 8'd1;
            end
        end
    end

    assign stat_cnt0 = cnt0_q;
    assign stat_cnt1 = cnt1_q;
`endif

endmodule
